// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller.
//   size_e      : request size encoding (byte / halfword / word / illegal)
//   err_code_e  : response error codes
//   state_e     : controller FSM states
//   check_request(): prioritised request validation used by the controller
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_SIZE  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // Illegal size outranks range, which outranks alignment. The range test
    // looks at the full 32-bit address so high addresses never alias.
    function automatic err_code_e check_request(input size_e       size,
                                                input logic [31:0] address,
                                                input logic [31:0] limit);
        err_code_e code;
        code = ERR_NONE;
        if (size == SIZE_ILLEGAL) begin
            code = ERR_SIZE;
        end else if (address >= limit) begin
            code = ERR_RANGE;
        end else if ((size == SIZE_HALF && address[0]) ||
                     (size == SIZE_WORD && address[1:0] != 2'b00)) begin
            code = ERR_ALIGN;
        end
        return code;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
//   master : requester side (drives req_*, address, data_write)
//   slave  : controller side (drives req_ready and the response signals)
interface data_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] address;
    logic [31:0] data_write;
    logic        rsp_valid;
    logic [31:0] data_out;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, address, data_write,
        input  req_ready, rsp_valid, data_out, err, err_code
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, address, data_write,
        output req_ready, rsp_valid, data_out, err, err_code
    );

endinterface

// File: rtl/mem_byte_array.sv
// DEPTH x 32-bit storage with per-byte write enables and a registered read.
//   clk     : clock
//   index   : word index
//   byte_en : per-lane write enable, bit i writes wdata[8i+7:8i]
//   wdata   : write data, already replicated onto the enabled lanes
//   rd_en   : load rdata with the addressed word on the next edge
//   rdata   : registered read data
// Contents are not reset.
module mem_byte_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] index,
    input  logic [3:0]        byte_en,
    input  logic [31:0]       wdata,
    input  logic              rd_en,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: accepts one byte/halfword/word load or store at a
// time, optionally waits WAIT_STATES cycles, accesses the byte array for one
// cycle and returns a one-cycle response strobe with data and error status.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response bus (slave side)
// Parameters: DEPTH (words), WAIT_STATES (0..15), ERR_READ_DATA (erroring load data).
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int          DEPTH         = 256,
    parameter int          WAIT_STATES   = 0,
    parameter logic [31:0] ERR_READ_DATA = 32'hEEEEEEEE
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus
);

    localparam int          ADDR_W     = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    state_e      state, state_next;
    logic [3:0]  count, count_next;
    logic        accept;

    logic        hold_write;
    logic        hold_unsigned;
    size_e       hold_size;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    err_code_e   req_err;
    logic        req_ok;
    logic [1:0]  lane;
    logic [3:0]  lane_en;
    logic [31:0] lane_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] data_out;
    logic        err;
    err_code_e   err_code;

    // Shift the addressed lane down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  sel,
                                                 input size_e       size,
                                                 input logic        zero_ext);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {sel, 3'b000};
        case (size)
            SIZE_BYTE: result = zero_ext ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = zero_ext ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default:   result = word;
        endcase
        return result;
    endfunction

    assign accept        = bus.req_valid && (state == ST_IDLE);
    assign bus.req_ready = (state == ST_IDLE);

    // Request capture: held stable from acceptance until the response.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_write    <= bus.req_write;
            hold_unsigned <= bus.req_unsigned;
            hold_size     <= size_e'(bus.req_size);
            hold_addr     <= bus.address;
            hold_wdata    <= bus.data_write;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        count_next = 4'(WAIT_STATES);
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign req_err = check_request(hold_size, hold_addr, ADDR_LIMIT);
    assign req_ok  = (req_err == ERR_NONE);
    assign lane    = hold_addr[1:0];

    // Replicate store data across the word so every lane sees its bytes;
    // the enables decide which lanes actually change.
    always_comb begin
        lane_en    = 4'b0000;
        lane_wdata = hold_wdata;
        case (hold_size)
            SIZE_BYTE: begin
                lane_en    = 4'b0001 << lane;
                lane_wdata = {4{hold_wdata[7:0]}};
            end
            SIZE_HALF: begin
                lane_en    = 4'b0011 << lane;
                lane_wdata = {2{hold_wdata[15:0]}};
            end
            SIZE_WORD: lane_en = 4'b1111;
            default:   lane_en = 4'b0000;
        endcase
    end

    // Writes commit only on the ACCESS edge; an async reset before that edge
    // drops the state out of ACCESS and so suppresses the write.
    assign mem_byte_en = (state == ST_ACCESS && hold_write && req_ok) ? lane_en : 4'b0000;

    mem_byte_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .index   (hold_addr[ADDR_W+1:2]),
        .byte_en (mem_byte_en),
        .wdata   (lane_wdata),
        .rd_en   (state == ST_ACCESS),
        .rdata   (mem_rdata)
    );

    // Response stage: registered outputs hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            data_out  <= 32'h0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            rsp_valid <= (state == ST_RESP);
            if (state == ST_RESP) begin
                err      <= !req_ok;
                err_code <= req_err;
                if (hold_write) begin
                    data_out <= 32'h0;
                end else if (!req_ok) begin
                    data_out <= ERR_READ_DATA;
                end else begin
                    data_out <= extract_load(mem_rdata, lane, hold_size, hold_unsigned);
                end
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.data_out  = data_out;
    assign bus.err       = err;
    assign bus.err_code  = err_code;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: two instances (WAIT_STATES 0 and 3) driven by
// directed and random requests; a reference model predicts each response,
// pushes it into a per-instance queue, and a monitor pops and compares
// whenever rsp_valid is seen.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    localparam int          DEPTH    = 32;
    localparam logic [31:0] ERR_DATA = 32'hEEEEEEEE;

    logic clk = 1'b0;
    logic rst_n0 = 1'b1;
    logic rst_n3 = 1'b1;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus0();
    data_mem_ctrl_if bus3();

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0), .ERR_READ_DATA(ERR_DATA)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(bus0));
    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(3), .ERR_READ_DATA(ERR_DATA)) dut3 (
        .clk(clk), .rst_n(rst_n3), .bus(bus3));

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [1:0]  code;
        bit          chk_data;
        int          accept_cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];
    int          acc3[$];
    logic [31:0] model [2][DEPTH];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: natural alignment, little-endian lanes, plain arithmetic.
    function automatic exp_t model_op(input int d, input bit wr, input logic [1:0] sz,
                                      input bit uns, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          nbytes, off, w, m;
        logic [31:0] word, mask;
        m = (d == 0) ? 0 : 1;
        e.data = 32'h0; e.err = 1'b0; e.code = 2'd0; e.chk_data = 1'b1; e.accept_cyc = 0;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off    = int'(a[1:0]);
        if (sz == 2'd3)                 e.code = 2'd3;
        else if (a >= 32'(4 * DEPTH))   e.code = 2'd1;
        else if ((off % nbytes) != 0)   e.code = 2'd2;
        if (e.code != 2'd0) begin
            e.err = 1'b1;
            if (wr) e.chk_data = 1'b0;
            else    e.data     = ERR_DATA;
            return e;
        end
        w    = int'(a >> 2);
        word = model[m][w];
        if (wr) begin
            for (int b = 0; b < nbytes; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
            model[m][w] = word;
        end else begin
            word = word >> (8 * off);
            if (nbytes < 4) begin
                mask = (32'h1 << (8 * nbytes)) - 32'h1;
                word = word & mask;
                if (!uns && word[8*nbytes-1]) word = word | ~mask;
            end
            e.data = word;
        end
        return e;
    endfunction

    task automatic drive(input int d, input bit v, input bit wr, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            bus0.req_valid = v; bus0.req_write = wr; bus0.req_size = sz;
            bus0.req_unsigned = uns; bus0.address = a; bus0.data_write = wd;
        end else begin
            bus3.req_valid = v; bus3.req_write = wr; bus3.req_size = sz;
            bus3.req_unsigned = uns; bus3.address = a; bus3.data_write = wd;
        end
    endtask

    task automatic issue(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep = 1'b0);
        exp_t e;
        int   waited;
        bit   rdy;
        waited = 0;
        @(negedge clk);
        drive(d, 1'b1, wr, sz, uns, a, wd);
        rdy = (d == 0) ? bus0.req_ready : bus3.req_ready;
        while (!rdy && waited < 50) begin
            @(negedge clk);
            waited++;
            rdy = (d == 0) ? bus0.req_ready : bus3.req_ready;
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL accept_timeout dut%0d: req_ready=0 required=1", d);
            drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
            return;
        end
        e = model_op(d, wr, sz, uns, a, wd);
        e.accept_cyc = cyc + 1;
        if (d == 0) q0.push_back(e);
        else begin
            q3.push_back(e);
            acc3.push_back(cyc + 1);
        end
        @(posedge clk);
        if (!keep) begin
            #1 drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic check_reset_state(input int d);
        logic rv, er, rd; logic [31:0] dout; logic [1:0] ec;
        rv   = (d == 0) ? bus0.rsp_valid : bus3.rsp_valid;
        er   = (d == 0) ? bus0.err       : bus3.err;
        rd   = (d == 0) ? bus0.req_ready : bus3.req_ready;
        dout = (d == 0) ? bus0.data_out  : bus3.data_out;
        ec   = (d == 0) ? bus0.err_code  : bus3.err_code;
        total++; if (rv !== 1'b0)    begin bad++; $display("FAIL rst_rsp_valid dut%0d: got %b required 0", d, rv); end
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL rst_data_out dut%0d: got %h required 0", d, dout); end
        total++; if (er !== 1'b0)    begin bad++; $display("FAIL rst_err dut%0d: got %b required 0", d, er); end
        total++; if (ec !== 2'd0)    begin bad++; $display("FAIL rst_err_code dut%0d: got %b required 00", d, ec); end
        total++; if (rd !== 1'b1)    begin bad++; $display("FAIL rst_req_ready dut%0d: got %b required 1", d, rd); end
    endtask

    task automatic check_rsp(input int d);
        exp_t        e;
        logic [31:0] dout;
        logic        er;
        logic [1:0]  ec;
        int          ws, qs;
        dout = (d == 0) ? bus0.data_out : bus3.data_out;
        er   = (d == 0) ? bus0.err      : bus3.err;
        ec   = (d == 0) ? bus0.err_code : bus3.err_code;
        ws   = (d == 0) ? 0 : 3;
        qs   = (d == 0) ? q0.size() : q3.size();
        total++;
        if (qs == 0) begin
            bad++;
            $display("FAIL unexpected_rsp dut%0d: rsp_valid=1 with no request outstanding", d);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q3.pop_front();
        total++; if (er !== e.err) begin bad++; $display("FAIL err dut%0d: got %b required %b", d, er, e.err); end
        total++; if (ec !== e.code) begin bad++; $display("FAIL err_code dut%0d: got %b required %b", d, ec, e.code); end
        if (e.chk_data) begin
            total++;
            if (dout !== e.data) begin bad++; $display("FAIL data_out dut%0d: got %h required %h", d, dout, e.data); end
        end
        total++;
        if (cyc != e.accept_cyc + 2 + ws) begin
            bad++;
            $display("FAIL latency dut%0d: rsp after edge %0d required edge %0d", d, cyc, e.accept_cyc + 2 + ws);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n0 && bus0.rsp_valid === 1'b1) check_rsp(0);
        if (rst_n3 && bus3.rsp_valid === 1'b1) check_rsp(3);
    end

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic init_mem(input int d);
        for (int w = 0; w < DEPTH; w++) issue(d, 1'b1, 2'd2, 1'b0, 32'(4 * w), 32'h0);
    endtask

    task automatic random_ops(input int d, input int n);
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        for (int i = 0; i < n; i++) begin
            r  = int'($urandom % 10);
            sz = (r < 9) ? 2'(r % 3) : 2'd3;
            if ($urandom % 10 == 0) a = 32'(4 * DEPTH) + ($urandom % 64);
            else                    a = $urandom % (4 * DEPTH);
            if ($urandom % 2 == 1) begin
                if (sz == 2'd1) a[0]   = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(d, 1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom);
            if ($urandom % 3 == 0) idle(d, int'($urandom % 4));
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        for (int w = 0; w < DEPTH; w++) begin
            model[0][w] = 32'h0;
            model[1][w] = 32'h0;
        end

        // Asynchronous reset: outputs must clear before any clock edge.
        #1 rst_n0 = 1'b0; rst_n3 = 1'b0;
        #1 check_reset_state(0); check_reset_state(3);
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1; rst_n3 = 1'b1;
        @(negedge clk);
        check_reset_state(0); check_reset_state(3);

        fork
            init_mem(0);
            init_mem(3);
        join

        // Word store/load round trip.
        issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        // Byte merge into an existing word, then word / signed / unsigned loads.
        issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        issue(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF80);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        issue(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        issue(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
        issue(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        issue(0, 1'b1, 2'd1, 1'b0, 32'h26, 32'hABCD9876);
        issue(0, 1'b0, 2'd1, 1'b1, 32'h26, 32'h0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
        // Error cases: misaligned, out of range (must not wrap), illegal size.
        issue(0, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
        issue(0, 1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h12345678);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        issue(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555);
        issue(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0);

        // Back-to-back throughput with req_valid held high.
        idle(3, 10);
        acc3.delete();
        for (int i = 0; i < 5; i++) issue(3, 1'b1, 2'd2, 1'b0, 32'(8 * i), $urandom, (i < 4));
        for (int i = 1; i < 5 && i < acc3.size(); i++) begin
            total++;
            if (acc3[i] - acc3[i-1] != 6) begin
                bad++;
                $display("FAIL throughput: accept spacing %0d required 6", acc3[i] - acc3[i-1]);
            end
        end

        // Reset during WAIT of a store: the store is dropped, no response.
        idle(3, 10);
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
        @(posedge clk);
        #1 drive(3, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n3 = 1'b0;
        #1 check_reset_state(3);
        repeat (2) @(negedge clk);
        rst_n3 = 1'b1;
        idle(3, 8);
        check_reset_state(3);
        issue(3, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        fork
            random_ops(0, 150);
            random_ops(3, 30);
        join

        for (int i = 0; i < 300 && (q0.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        total++;
        if (q0.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding dut0=%0d dut3=%0d required 0", q0.size(), q3.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored; power of two, 4..4096.
REQ-002 Parameter WAIT_STATES, default 0: extra cycles between request acceptance and memory access; range 0..15.
REQ-003 Parameter ERR_READ_DATA, default 32'hEEEEEEEE: data_out value returned by an erroring read.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for word loads and stores.
REQ-011 address  input  32  byte address, little-endian.
REQ-012 data_write  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-013 rsp_valid  output  1  one-cycle response strobe.
REQ-014 data_out  output  32  load result, valid when rsp_valid is high.
REQ-015 err  output  1  request failed; valid when rsp_valid is high.
REQ-016 err_code  output  2  00 none, 01 out of range, 10 misaligned, 11 illegal size.

Function
REQ-017 FSM states: IDLE, WAIT, ACCESS, RESP; req_ready shall be 1 only in IDLE.
REQ-018 Handshake: req_valid && req_ready at an edge captures address, data, size, write, unsigned into holding registers; inputs are ignored in any other cycle.
REQ-019 Transition from IDLE on acceptance to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES), else to ACCESS.
REQ-020 In WAIT, counter decrements each cycle; at counter==1 the next state is ACCESS.
REQ-021 ACCESS performs the memory read/write for one cycle, then goes to RESP.
REQ-022 RESP drives rsp_valid=1 for exactly one cycle, then goes to IDLE; the response is not stalled.
REQ-023 Latency: acceptance at edge k gives rsp_valid high in the cycle after edge k+2+WAIT_STATES; the next acceptance is earliest at edge k+3+WAIT_STATES.
REQ-024 Error checks, in priority order:
  - size 11 -> code 11;
  - address >= 4*DEPTH -> code 01;
  - halfword with address[0]=1, or word with address[1:0]!=0 -> code 10.
REQ-025 An erroring store shall not modify memory; an erroring load returns ERR_READ_DATA; err=1.
REQ-026 Store: byte and halfword stores write only the addressed lanes (lane = address[1:0]); other bytes of the word are preserved.
REQ-027 Load: select the lane by address[1:0], then extend to 32 bits per req_unsigned.
REQ-028 A successful store returns data_out=0 and err=0.
REQ-029 Word index = address[log2(DEPTH)+1:2]; address bits above the range are checked (REQ-024) and never wrap.
REQ-030 data_out, err and err_code hold their values between responses.

Reset
REQ-031 On rst_n low, regardless of clk:
  - state = IDLE, counter = 0;
  - rsp_valid = 0, data_out = 0, err = 0, err_code = 0;
  - req_ready = 1 after release.
REQ-032 Reset during WAIT or ACCESS shall abandon the request; a store not yet committed at the ACCESS edge shall not be written.
REQ-033 Memory contents are not cleared by reset; initial simulation content is zero.

Structure
REQ-034 Shared package mem_pkg holds the size encodings, err_code encodings and FSM state type.
REQ-035 Sub-module mem_byte_array holds DEPTH x 32 storage with a 4-bit byte write enable and a registered read; lane extract/merge stays in data_mem_ctrl.

Verification
REQ-036 Word store then load at 0x10 of 0xDEADBEEF (WAIT_STATES=0): load returns 0xDEADBEEF, err=0; rsp_valid 3 cycles after acceptance.
REQ-037 Store byte 0x80 at 0x21 into word 0x11223344, then:
  - word load gives 0x11228044;
  - lb gives 0xFFFFFF80;
  - lbu gives 0x00000080.
REQ-038 Halfword load at 0x13 -> err=1, code 10, data_out=0xEEEEEEEE; word store at 4*DEPTH -> code 01, memory unchanged.
REQ-039 WAIT_STATES=3: rsp_valid 6 cycles after acceptance; req_valid held high continuously gives one acceptance per 6 cycles.
REQ-040 Assert rst_n low during WAIT of a store to 0x40 (old 0x0): after reset, a load of 0x40 returns 0x0, and rsp_valid is never raised for the aborted request.
